// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller: sequences M0-M5 over a 2^size x length memory and flags read mismatches.
// Optional MARCH_FAIL_LOG_EN compiles first-failure address capture; otherwise fail_addr is tied to zero.
module march_bist_ctrl #(
  parameter int size   = 6,
  parameter int length = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              csout,
  output logic              rwbarout,
  output logic [size-1:0]   address,
  output logic [length-1:0] dataout,
  input  logic [length-1:0] datain,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [size-1:0]   fail_addr
);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  localparam logic [size-1:0] ADDR_MAX = '1;

  state_t            state, state_nxt;
  logic [size-1:0]   addr, addr_nxt;
  logic              phase, phase_nxt;
  logic              last_up, last_dn, rd_ones, up, accept;
  logic [length-1:0] exp_data;
  logic [length-1:0] exp_p1;
  logic              vld_p1;
  logic              mismatch;

  function automatic logic [length-1:0] pattern(input logic ones);
    return ones ? {length{1'b1}} : {length{1'b0}};
  endfunction

  assign last_up = (addr == ADDR_MAX);
  assign last_dn = (addr == '0);
  assign address = addr;
  assign accept  = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    phase_nxt = phase;
    csout     = 1'b0;
    rwbarout  = 1'b1;
    dataout   = '0;
    exp_data  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    rd_ones   = 1'b0;
    up        = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt = M0;
          addr_nxt  = '0;
          phase_nxt = 1'b0;
        end
      end
      M0: begin
        busy     = 1'b1;
        csout    = 1'b1;
        rwbarout = 1'b0;
        if (last_up) begin
          state_nxt = M1;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      // Read/write elements: phase 0 reads, phase 1 writes the complement, then step address.
      M1, M2, M3, M4: begin
        busy      = 1'b1;
        csout     = 1'b1;
        rwbarout  = !phase;
        rd_ones   = (state == M2) || (state == M4);
        up        = (state == M1) || (state == M2);
        exp_data  = pattern(rd_ones);
        dataout   = phase ? pattern(!rd_ones) : '0;
        phase_nxt = !phase;
        if (phase) begin
          if (up ? last_up : last_dn) begin
            case (state)
              M1:      begin state_nxt = M2; addr_nxt = '0;       end
              M2:      begin state_nxt = M3; addr_nxt = ADDR_MAX; end
              M3:      begin state_nxt = M4; addr_nxt = ADDR_MAX; end
              default: begin state_nxt = M5; addr_nxt = '0;       end
            endcase
          end else begin
            addr_nxt = up ? addr + 1'b1 : addr - 1'b1;
          end
        end
      end
      M5: begin
        busy  = 1'b1;
        csout = 1'b1;
        if (last_up) state_nxt = DRAIN;
        else         addr_nxt  = addr + 1'b1;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      phase  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      phase  <= phase_nxt;
      vld_p1 <= csout && rwbarout;
    end
  end

  // ---- stage p1: expected word registered with each read, compared against datain next cycle
  always_ff @(posedge clk) begin
    exp_p1 <= exp_data;
  end

  assign mismatch = vld_p1 && (datain != exp_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fail <= 1'b0;
    else if (accept)   fail <= 1'b0;
    else if (mismatch) fail <= 1'b1;
  end

`ifdef MARCH_FAIL_LOG_EN
  logic [size-1:0] addr_p1;

  always_ff @(posedge clk) begin
    addr_p1 <= addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    fail_addr <= '0;
    else if (accept)            fail_addr <= '0;
    else if (mismatch && !fail) fail_addr <= addr_p1;
  end
`else
  assign fail_addr = '0;
`endif

endmodule
